// File: rtl/lcd_display_driver.sv
// 8-bit character LCD writer: power-up init list, then DISPLAY_OFF or a two-line
// SHOW of instruction mnemonic, register number and signed 16-bit value.
module lcd_display_driver #(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned EN_PULSE_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  operation,
  input  logic [2:0]  opcode,
  input  logic [3:0]  addr,
  input  logic [15:0] data_addr,
  output logic        EN,
  output logic        RW,
  output logic        RS,
  output logic [7:0]  DATA,
  output logic        done
);
  typedef enum logic [2:0] {S_POWERUP, S_NEXT, S_SETUP, S_PULSE, S_WAIT, S_READY} state_t;
  typedef enum logic [1:0] {L_INIT, L_OFF, L_SHOW} list_t;

  state_t      state_q, state_d;
  list_t       list_q;
  logic [31:0] cnt_q;
  logic [4:0]  idx_q;
  logic [1:0]  last_op_q;
  logic [2:0]  opcode_q;
  logic [3:0]  addr_q;
  logic        sign_q;
  logic        rs_q;
  logic [7:0]  data_q;
  logic [35:0] bcd_sh_q;
  logic [4:0]  bcd_cnt_q;

  logic [19:0] bcd_adj;
  logic [15:0] magnitude;
  logic [31:0] mnemonic;
  logic [31:0] wait_len;
  logic [4:0]  list_len;
  logic [7:0]  cur_byte;
  logic        cur_rs;
  logic        accept;

  assign accept    = (state_q == S_READY) && (operation == 2'd1 || operation == 2'd2) &&
                     (operation != last_op_q);
  assign magnitude = data_addr[15] ? (~data_addr + 16'd1) : data_addr;
  assign wait_len  = (!rs_q && data_q == 8'h01) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;

  // Double-dabble add-3 correction on each BCD digit before the shift
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dabble
      assign bcd_adj[gi*4 +: 4] = (bcd_sh_q[16+gi*4 +: 4] >= 4'd5) ?
                                  bcd_sh_q[16+gi*4 +: 4] + 4'd3 : bcd_sh_q[16+gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    mnemonic = "LOAD";
    case (opcode_q)
      3'd1: mnemonic = "ADD ";
      3'd2: mnemonic = "ADDI";
      3'd3: mnemonic = "SUB ";
      3'd4: mnemonic = "SUBI";
      3'd5: mnemonic = "MUL ";
      3'd6: mnemonic = "CLR ";
      3'd7: mnemonic = "DPL ";
      default: mnemonic = "LOAD";
    endcase
  end

  always_comb begin
    list_len = 5'd0;
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    case (list_q)
      L_INIT: begin
        list_len = 5'd4;
        case (idx_q)
          5'd0:    cur_byte = 8'h38;
          5'd1:    cur_byte = 8'h0C;
          5'd2:    cur_byte = 8'h06;
          default: cur_byte = 8'h01;
        endcase
      end
      L_OFF: begin
        list_len = 5'd1;
        cur_byte = 8'h08;
      end
      default: begin
        list_len = 5'd18;
        cur_rs   = 1'b1;
        case (idx_q)
          5'd0:  begin cur_byte = 8'h0C; cur_rs = 1'b0; end
          5'd1:  begin cur_byte = 8'h01; cur_rs = 1'b0; end
          5'd2:  begin cur_byte = 8'h80; cur_rs = 1'b0; end
          5'd3:  cur_byte = mnemonic[31:24];
          5'd4:  cur_byte = mnemonic[23:16];
          5'd5:  cur_byte = mnemonic[15:8];
          5'd6:  cur_byte = mnemonic[7:0];
          5'd7:  cur_byte = 8'h20;
          5'd8:  cur_byte = 8'h52;
          5'd9:  cur_byte = (addr_q >= 4'd10) ? 8'h31 : 8'h30;
          5'd10: cur_byte = {4'h3, (addr_q >= 4'd10) ? addr_q - 4'd10 : addr_q};
          5'd11: begin cur_byte = 8'hC0; cur_rs = 1'b0; end
          5'd12: cur_byte = sign_q ? 8'h2D : 8'h2B;
          5'd13: cur_byte = {4'h3, bcd_sh_q[35:32]};
          5'd14: cur_byte = {4'h3, bcd_sh_q[31:28]};
          5'd15: cur_byte = {4'h3, bcd_sh_q[27:24]};
          5'd16: cur_byte = {4'h3, bcd_sh_q[23:20]};
          default: cur_byte = {4'h3, bcd_sh_q[19:16]};
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_POWERUP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_POWERUP: if (cnt_q == POWERUP_CYC - 32'd1) state_d = S_NEXT;
      S_NEXT:    state_d = (idx_q == list_len) ? S_READY : S_SETUP;
      S_SETUP:   state_d = S_PULSE;
      S_PULSE:   if (cnt_q == EN_PULSE_CYC - 32'd1) state_d = S_WAIT;
      S_WAIT:    if (cnt_q == wait_len - 32'd1) state_d = S_NEXT;
      S_READY:   if (accept) state_d = S_NEXT;
      default:   state_d = S_POWERUP;
    endcase
  end

  always_comb begin
    EN   = 1'b0;
    done = 1'b0;
    case (state_q)
      S_PULSE: EN = 1'b1;
      S_READY: done = 1'b1;
      default: ;
    endcase
  end

  assign RW   = 1'b0;
  assign RS   = rs_q;
  assign DATA = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      list_q    <= L_INIT;
      last_op_q <= '0;
      opcode_q  <= '0;
      addr_q    <= '0;
      sign_q    <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= '0;
      bcd_sh_q  <= '0;
      bcd_cnt_q <= '0;
    end else begin
      cnt_q <= (state_d != state_q) ? '0 : cnt_q + 32'd1;
      if (state_q == S_NEXT && idx_q != list_len) begin
        data_q <= cur_byte;
        rs_q   <= cur_rs;
        idx_q  <= idx_q + 5'd1;
      end
      if (accept) begin
        last_op_q <= operation;
        opcode_q  <= opcode;
        addr_q    <= addr;
        sign_q    <= data_addr[15];
        list_q    <= (operation == 2'd1) ? L_OFF : L_SHOW;
        idx_q     <= '0;
        bcd_sh_q  <= {20'd0, magnitude};
        bcd_cnt_q <= 5'd16;
      end else begin
        if (state_q == S_READY && (operation == 2'd0 || operation == 2'd3))
          last_op_q <= 2'd0;
        if (bcd_cnt_q != 5'd0) begin
          bcd_sh_q  <= {bcd_adj[18:0], bcd_sh_q[15:0], 1'b0};
          bcd_cnt_q <= bcd_cnt_q - 5'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_display_driver.sv
// Bench for lcd_display_driver: captures every EN pulse and compares against a
// string/arithmetic model of the init, SHOW and DISPLAY_OFF write lists.
`timescale 1ns/1ps
module tb_lcd_display_driver;
  localparam int PU = 4, ENP = 2, CW = 3, CLW = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  operation = 2'd0;
  logic [2:0]  opcode = 3'd0;
  logic [3:0]  addr = 4'd0;
  logic [15:0] data_addr = 16'd0;
  logic        EN, RW, RS, done;
  logic [7:0]  DATA;

  int n_checks = 0;
  int n_fail = 0;

  bit [8:0] cap_b[$];
  int       cap_w[$];
  int       cap_g[$];
  bit       cap_s[$];
  bit [8:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_display_driver #(
    .POWERUP_CYC(PU), .EN_PULSE_CYC(ENP), .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .opcode(opcode), .addr(addr),
    .data_addr(data_addr), .EN(EN), .RW(RW), .RS(RS), .DATA(DATA), .done(done)
  );

  // Pulse recorder: {RS,DATA} at EN rise, high width, preceding low gap, stability while high
  initial begin : monitor
    bit prev_en;
    int low_cnt;
    int hi_cnt;
    bit [8:0] hold;
    prev_en = 1'b0; low_cnt = 0; hi_cnt = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (EN === 1'b1) begin
        if (!prev_en) begin
          cap_b.push_back({RS, DATA});
          cap_g.push_back(low_cnt);
          cap_s.push_back(1'b1);
          hold = {RS, DATA};
          hi_cnt = 1;
        end else begin
          hi_cnt++;
          if ({RS, DATA} !== hold && cap_s.size() > 0) cap_s[cap_s.size()-1] = 1'b0;
        end
        prev_en = 1'b1;
      end else begin
        if (prev_en) begin
          cap_w.push_back(hi_cnt);
          low_cnt = 1;
        end else begin
          low_cnt++;
        end
        prev_en = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic string mnem(int opc);
    case (opc)
      0: return "LOAD";
      1: return "ADD ";
      2: return "ADDI";
      3: return "SUB ";
      4: return "SUBI";
      5: return "MUL ";
      6: return "CLR ";
      default: return "DPL ";
    endcase
  endfunction

  function automatic void model_init();
    exp_q.delete();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006); exp_q.push_back(9'h001);
  endfunction

  function automatic void model_show(int opc, int ad, int d);
    string m;
    int mag;
    int p;
    m = mnem(opc);
    exp_q.delete();
    exp_q.push_back(9'h00C); exp_q.push_back(9'h001); exp_q.push_back(9'h080);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'(m[i])});
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b1, 8'h52});
    exp_q.push_back({1'b1, 8'(48 + ad / 10)});
    exp_q.push_back({1'b1, 8'(48 + ad % 10)});
    exp_q.push_back(9'h0C0);
    mag = (d >= 32768) ? 65536 - d : d;
    exp_q.push_back({1'b1, (d >= 32768) ? 8'h2D : 8'h2B});
    p = 10000;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 8'(48 + (mag / p) % 10)});
      p = p / 10;
    end
  endfunction

  function automatic int gap_after(bit [8:0] prev);
    return ((prev == 9'h001) ? CLW : CW) + 2;
  endfunction

  task automatic clear_caps();
    cap_b.delete(); cap_w.delete(); cap_g.delete(); cap_s.delete();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    operation = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (EN !== 1'b0)   begin n_fail++; $display("FAIL reset_en: got %b want 0", EN); end
    n_checks++; if (RW !== 1'b0)   begin n_fail++; $display("FAIL reset_rw: got %b want 0", RW); end
    n_checks++; if (RS !== 1'b0)   begin n_fail++; $display("FAIL reset_rs: got %b want 0", RS); end
    n_checks++; if (DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", DATA); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    $display("reset: EN=%b RW=%b RS=%b DATA=%h done=%b", EN, RW, RS, DATA, done);
  endtask

  task automatic test_init();
    bit ok;
    clear_caps();
    model_init();
    rst_n = 1'b1;
    wait_done(300, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL init_timeout: done got 0 want 1"); end
    n_checks++;
    if (cap_b.size() != 4) begin n_fail++; $display("FAIL init_count: got %0d want 4", cap_b.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (cap_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL init_byte[%0d]: got %h want %h", i, cap_b[i], exp_q[i]); end
        n_checks++; if (cap_w[i] !== ENP) begin n_fail++; $display("FAIL init_width[%0d]: got %0d want %0d", i, cap_w[i], ENP); end
        if (i > 0) begin
          n_checks++; if (cap_g[i] !== gap_after(exp_q[i-1])) begin n_fail++; $display("FAIL init_gap[%0d]: got %0d want %0d", i, cap_g[i], gap_after(exp_q[i-1])); end
        end
      end
    end
    $display("init: %0d writes, done=%b", cap_b.size(), done);
  endtask

  task automatic test_show();
    bit ok;
    logic [2:0] o;
    logic [3:0] a;
    logic [15:0] d;
    for (int k = 0; k < 10; k++) begin
      case (k)
        0: begin o = 3'd2; a = 4'd7;  d = 16'h0400; end
        1: begin o = 3'd7; a = 4'd15; d = 16'h8000; end
        2: begin o = 3'd0; a = 4'd0;  d = 16'hFFFF; end
        3: begin o = 3'd6; a = 4'd10; d = 16'h0000; end
        default: begin o = 3'($urandom); a = 4'($urandom); d = 16'($urandom); end
      endcase
      operation = 2'd0;
      @(negedge clk);
      clear_caps();
      model_show(int'(o), int'(a), int'(d));
      operation = 2'd2; opcode = o; addr = a; data_addr = d;
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL show_done_drop: got %b want 0", done); end
      opcode = 3'($urandom); addr = 4'($urandom); data_addr = 16'($urandom);
      wait_done(1000, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL show_timeout: done got 0 want 1"); end
      n_checks++;
      if (cap_b.size() != 18) begin n_fail++; $display("FAIL show_count: got %0d want 18", cap_b.size()); end
      else begin
        for (int i = 0; i < 18; i++) begin
          n_checks++; if (cap_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL show_byte[%0d]: got %h want %h", i, cap_b[i], exp_q[i]); end
          n_checks++; if (cap_w[i] !== ENP || cap_s[i] !== 1'b1) begin n_fail++; $display("FAIL show_pulse[%0d]: width %0d stable %b want %0d 1", i, cap_w[i], cap_s[i], ENP); end
          if (i > 0) begin
            n_checks++; if (cap_g[i] !== gap_after(exp_q[i-1])) begin n_fail++; $display("FAIL show_gap[%0d]: got %0d want %0d", i, cap_g[i], gap_after(exp_q[i-1])); end
          end
        end
      end
      $display("show: opcode=%0d addr=%0d data=%h writes=%0d", o, a, d, cap_b.size());
    end
  endtask

  task automatic test_hold_repeat();
    bit ok;
    clear_caps();
    repeat (80) @(negedge clk);
    n_checks++; if (cap_b.size() != 0) begin n_fail++; $display("FAIL hold_no_pulse: got %0d pulses want 0", cap_b.size()); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b want 1", done); end
    operation = 2'd0;
    @(negedge clk);
    model_show(5, 15, 16'h7FFF);
    operation = 2'd2; opcode = 3'd5; addr = 4'd15; data_addr = 16'h7FFF;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL repeat_done_drop: got %b want 0", done); end
    wait_done(1000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL repeat_timeout: done got 0 want 1"); end
    n_checks++;
    if (cap_b.size() != 18) begin n_fail++; $display("FAIL repeat_count: got %0d want 18", cap_b.size()); end
    else begin
      for (int i = 0; i < 18; i++) begin
        n_checks++; if (cap_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL repeat_byte[%0d]: got %h want %h", i, cap_b[i], exp_q[i]); end
      end
    end
    $display("hold/repeat: writes=%0d done=%b", cap_b.size(), done);
  endtask

  task automatic test_off_during_init();
    bit ok;
    rst_n = 1'b0;
    operation = 2'd1;
    repeat (2) @(negedge clk);
    clear_caps();
    model_init();
    exp_q.push_back(9'h008);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cap_b.size() == 5 && done === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL off_timeout: writes %0d done %b want 5 1", cap_b.size(), done); end
    n_checks++;
    if (cap_b.size() != 5) begin n_fail++; $display("FAIL off_count: got %0d want 5", cap_b.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++; if (cap_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL off_byte[%0d]: got %h want %h", i, cap_b[i], exp_q[i]); end
      end
      n_checks++; if (cap_g[4] !== CLW + 4) begin n_fail++; $display("FAIL off_first_ready: gap got %0d want %0d", cap_g[4], CLW + 4); end
    end
    $display("off during init: writes=%0d done=%b", cap_b.size(), done);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    logic [2:0] o;
    logic [3:0] a;
    logic [15:0] d;
    o = 3'($urandom); a = 4'($urandom); d = 16'($urandom);
    operation = 2'd0;
    @(negedge clk);
    clear_caps();
    model_show(int'(o), int'(a), int'(d));
    operation = 2'd2; opcode = o; addr = a; data_addr = d;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cap_b.size() == 15 && EN === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_reach: writes %0d want 15", cap_b.size()); end
    rst_n = 1'b0;
    operation = 2'd0;
    @(negedge clk);
    n_checks++; if (EN !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %b want 0", EN); end
    n_checks++; if ({RS, DATA} !== 9'h000) begin n_fail++; $display("FAIL midrst_bus: got %h want 000", {RS, DATA}); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    n_checks++; if (cap_b.size() < 15 || cap_b[14] !== exp_q[14]) begin n_fail++; $display("FAIL midrst_char: interrupted write mismatch, writes %0d", cap_b.size()); end
    @(negedge clk);
    clear_caps();
    model_init();
    rst_n = 1'b1;
    wait_done(300, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_timeout: done got 0 want 1"); end
    n_checks++;
    if (cap_b.size() != 4) begin n_fail++; $display("FAIL midrst_init_count: got %0d want 4", cap_b.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (cap_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_init_byte[%0d]: got %h want %h", i, cap_b[i], exp_q[i]); end
      end
    end
    $display("reset mid-write: reinit writes=%0d done=%b", cap_b.size(), done);
  endtask

  initial begin : main
    test_reset();
    test_init();
    test_show();
    test_hold_repeat();
    test_off_during_init();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_display_driver.md
LCD_DISPLAY_DRIVER -- requirements
Module: lcd_display_driver

Interface
REQ-001 Parameter POWERUP_CYC, default 750000, meaning power-up wait in clk cycles before the first LCD write.
REQ-002 Parameter EN_PULSE_CYC, default 25, meaning EN high width in clk cycles.
REQ-003 Parameter CMD_WAIT_CYC, default 2500, meaning post-write wait for ordinary commands and characters.
REQ-004 Parameter CLEAR_WAIT_CYC, default 100000, meaning post-write wait after command 0x01.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 operation  input  2  request code: 0 IDLE, 1 DISPLAY_OFF, 2 SHOW, 3 reserved (treated as IDLE).
REQ-008 opcode  input  3  CPU instruction code shown on line 1.
REQ-009 addr  input  4  register address shown on line 1.
REQ-010 data_addr  input  16  two's-complement value shown on line 2.
REQ-011 EN  output  1  LCD enable strobe.
REQ-012 RW  output  1  LCD read/write; constant 0 (write only).
REQ-013 RS  output  1  LCD register select: 0 command, 1 character.
REQ-014 DATA  output  8  LCD 8-bit data bus.
REQ-015 done  output  1  level; high only in READY state.

Function
REQ-016 States SHALL be POWERUP, NEXT, SETUP, PULSE, WAIT, READY.
REQ-017 POWERUP: count POWERUP_CYC cycles, then NEXT with the init list: 0x38, 0x0C, 0x06, 0x01.
REQ-018 NEXT: if the active list is exhausted, go to READY; otherwise load the next byte into DATA and its RS value, then go to SETUP.
REQ-019 Byte write: SETUP holds EN=0 for 1 cycle; PULSE holds EN=1 for EN_PULSE_CYC cycles; WAIT holds EN=0 for CMD_WAIT_CYC cycles (CLEAR_WAIT_CYC if the byte was command 0x01); then NEXT.
REQ-020 RS and DATA SHALL be stable from SETUP through the end of WAIT.
REQ-021 Acceptance happens only in READY. A request is accepted when operation is 1 or 2 and differs from last_op. On acceptance, last_op is set to operation, opcode, addr and data_addr are latched, and done drops the next cycle.
REQ-022 last_op SHALL clear to 0 whenever operation is 0 or 3 in READY, so an identical request is re-accepted only after an IDLE gap.
REQ-023 A request held during init or any sequence SHALL be accepted on the first READY cycle.
REQ-024 DISPLAY_OFF list: command 0x08.
REQ-025 SHOW list, 18 writes: 0x0C; 0x01; 0x80; 8 characters (mnemonic, space, 'R', two decimal digits of addr); 0xC0; 6 characters (sign, 5 decimal digits).
REQ-026 Mnemonics by opcode: 0 "LOAD", 1 "ADD ", 2 "ADDI", 3 "SUB ", 4 "SUBI", 5 "MUL ", 6 "CLR ", 7 "DPL ".
REQ-027 addr SHALL be shown as "00" to "15".
REQ-028 Sign character is '+' when data_addr[15]=0 and '-' otherwise. The magnitude is the 16-bit unsigned two's-complement negate, so -32768 gives 32768.
REQ-029 Digits SHALL always be 5, with leading zeros kept.
REQ-030 Binary-to-BCD conversion SHALL be sequential (shift-add-3, 16 iterations), started on acceptance, and complete before the 0xC0 write begins.
REQ-031 Latched inputs SHALL be used throughout a sequence; input changes mid-sequence are ignored.
REQ-032 Characters are ASCII: '0' is 0x30, 'R' is 0x52, space is 0x20, '+' is 0x2B, '-' is 0x2D.

Reset
REQ-033 While rst_n=0 at a clock edge, the next state SHALL be: EN=0, RW=0, RS=0, DATA=0x00, done=0, last_op=0, state POWERUP, all counters 0.
REQ-034 Reset asserted mid-write SHALL force EN=0 on the next cycle and restart the full power-up and init sequence.

Verification (parameters 4/2/3/6)
REQ-035 Release reset, operation=0 -> 4 EN pulses carrying 0x38, 0x0C, 0x06, 0x01 with RS=0, each 2 cycles high; done=1 afterwards.
REQ-036 After init, operation=2, opcode=2, addr=7, data_addr=0x0400 -> DATA sequence 0x0C, 0x01, 0x80, "ADDI R07", 0xC0, "+01024"; RS=1 only on characters; done=1 at end.
REQ-037 SHOW with data_addr=0x8000 -> line 2 "-32768"; with 0xFFFF -> "-00001"; with 0x0000 -> "+00000".
REQ-038 Hold operation=2 after completion -> no further EN pulses. Go to 0 for 1 cycle, then back to 2 -> the full SHOW sequence repeats.
REQ-039 operation=1 issued during init -> accepted on the first READY cycle; single write 0x08, RS=0; done returns high.
REQ-040 rst_n pulled low during PULSE of line-2 character 3 -> EN=0 on the next cycle, outputs at reset values, init sequence restarts.
